// File: rtl/adc_packetizer_pkg.sv
// adc_pkt_pkg: FSM state encoding and framing constants shared by adc_packetizer.
package adc_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC0,
        ST_SYNC1,
        ST_SEQ,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK
    } pkt_state_t;

    localparam logic [7:0]  DEF_SYNC0 = 8'hA5;
    localparam logic [7:0]  DEF_SYNC1 = 8'h5A;
    localparam int unsigned HDR_BYTES = 4;

endpackage

// File: rtl/adc_packetizer.sv
// adc_packetizer: pops ADC bytes from a standard-mode FIFO and frames them as sync/seq/len/payload packets.
// Define PKT_CHECKSUM_EN to append an 8-bit payload checksum byte carrying m_tlast.
module adc_packetizer
    import adc_pkt_pkg::*;
#(
    parameter int unsigned PAYLOAD_LEN = 64,
    parameter logic [7:0]  SYNC0       = DEF_SYNC0,
    parameter logic [7:0]  SYNC1       = DEF_SYNC1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        fifo_rst_busy,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [7:0]  fifo_dout,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    input  logic        m_tready,
    output logic        busy,
    output logic [15:0] pkt_count
);

    pkt_state_t  r_state;
    logic [7:0]  r_tdata;
    logic        r_tvalid;
    logic        r_tlast;
    logic        r_rd_pend;
    logic [7:0]  r_reads_left;
    logic [7:0]  r_seq;
    logic [15:0] r_pkt_count;
`ifdef PKT_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    logic w_free;
    logic w_last_acc;
    logic w_rd_en;

    assign w_free     = !r_tvalid || m_tready;
    assign w_last_acc = r_tvalid && r_tlast && m_tready;
    // A pop is only issued into a free register, so the byte arriving next clk always has room.
    assign w_rd_en    = (r_state == ST_PAYLOAD) && !fifo_empty && !fifo_rst_busy &&
                        !r_rd_pend && (r_reads_left != '0) && w_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_reads_left <= '0;
            r_seq        <= '0;
            r_pkt_count  <= '0;
`ifdef PKT_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_rd_pend <= w_rd_en;
            if (w_rd_en) begin
                r_reads_left <= r_reads_left - 8'd1;
            end
            if (w_free) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (en && !fifo_empty && !fifo_rst_busy) begin
                        r_state <= ST_SYNC0;
                    end
                end
                ST_SYNC0: begin
                    if (w_free) begin
                        r_tdata  <= SYNC0;
                        r_tvalid <= 1'b1;
                        r_state  <= ST_SYNC1;
                    end
                end
                ST_SYNC1: begin
                    if (w_free) begin
                        r_tdata  <= SYNC1;
                        r_tvalid <= 1'b1;
                        r_state  <= ST_SEQ;
                    end
                end
                ST_SEQ: begin
                    if (w_free) begin
                        r_tdata  <= r_seq;
                        r_tvalid <= 1'b1;
                        r_state  <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (w_free) begin
                        r_tdata      <= 8'(PAYLOAD_LEN);
                        r_tvalid     <= 1'b1;
                        r_reads_left <= 8'(PAYLOAD_LEN);
`ifdef PKT_CHECKSUM_EN
                        r_csum       <= '0;
`endif
                        r_state      <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (r_rd_pend) begin
                        r_tdata  <= fifo_dout;
                        r_tvalid <= 1'b1;
`ifdef PKT_CHECKSUM_EN
                        r_csum   <= r_csum + fifo_dout;
                        if (r_reads_left == '0) begin
                            r_state <= ST_CHK;
                        end
`else
                        r_tlast  <= (r_reads_left == '0);
`endif
                    end
                end
`ifdef PKT_CHECKSUM_EN
                ST_CHK: begin
                    if (w_free && !r_tlast) begin
                        r_tdata  <= r_csum;
                        r_tvalid <= 1'b1;
                        r_tlast  <= 1'b1;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase

            // Packet closes only when the sink takes the tlast byte; overrides the state update above.
            if (w_last_acc) begin
                r_state     <= ST_IDLE;
                r_seq       <= r_seq + 8'd1;
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign m_tdata    = r_tdata;
    assign m_tvalid   = r_tvalid;
    assign m_tlast    = r_tlast;
    assign busy       = (r_state != ST_IDLE);
    assign pkt_count  = r_pkt_count;

endmodule

// File: tb/tb_adc_packetizer.sv
// tb_adc_packetizer: randomized bench with a FIFO model and a packet-level reference for adc_packetizer.
// Honours PKT_CHECKSUM_EN to expect the trailing checksum byte.
module tb_adc_packetizer;
    import adc_pkt_pkg::*;

    localparam int unsigned PLEN = 4;
`ifdef PKT_CHECKSUM_EN
    localparam int unsigned CHK_B = 1;
`else
    localparam int unsigned CHK_B = 0;
`endif
    localparam int unsigned PKT_BYTES = HDR_BYTES + PLEN + CHK_B;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        fifo_rst_busy;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_dout;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic        busy;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    adc_packetizer #(
        .PAYLOAD_LEN(PLEN),
        .SYNC0      (8'hA5),
        .SYNC1      (8'h5A)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .fifo_rst_busy(fifo_rst_busy),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_dout    (fifo_dout),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tlast      (m_tlast),
        .m_tready     (m_tready),
        .busy         (busy),
        .pkt_count    (pkt_count)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [7:0]  fq[$];
    logic [7:0]  src_q[$];
    bit          pop_pending = 0;
    bit          rdy_rand = 0;
    int unsigned pops = 0;

    int unsigned pos = 0;
    logic [7:0]  seq_m = 8'h00;
    logic [7:0]  sum_m = 8'h00;
    int unsigned pkts_m = 0;

    bit          stall_prev = 0;
    logic [7:0]  stall_data;
    logic        stall_last;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        src_q.push_back(b);
    endtask

    // Packet-level reference: header, then the FIFO bytes in push order, then optional sum.
    task automatic model_accept(input logic [7:0] d, input logic l);
        logic [7:0] e;
        if (pos == 0)                     e = 8'hA5;
        else if (pos == 1)                e = 8'h5A;
        else if (pos == 2)                e = seq_m;
        else if (pos == 3)                e = 8'(PLEN);
        else if (pos < HDR_BYTES + PLEN) begin
            e = (src_q.size() > 0) ? src_q.pop_front() : 8'h00;
            sum_m = sum_m + e;
        end else                          e = sum_m;
        chk_eq($sformatf("byte%0d", pos), d, e);
        chk_eq("tlast", l, (pos == PKT_BYTES - 1));
        if (pos == PKT_BYTES - 1) begin
            pos = 0;
            sum_m = 8'h00;
            seq_m = seq_m + 8'd1;
            pkts_m++;
        end else begin
            pos++;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (pop_pending) begin
            fifo_dout = fq.pop_front();
            pop_pending = 0;
        end
        fifo_empty = (fq.size() == 0);
        m_tready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        #1;
        if (stall_prev) begin
            chk_eq("hold_valid", m_tvalid, 1);
            chk_eq("hold_data", m_tdata, stall_data);
            chk_eq("hold_last", m_tlast, stall_last);
        end
        stall_prev = m_tvalid && !m_tready;
        stall_data = m_tdata;
        stall_last = m_tlast;
        if (fifo_rd_en) begin
            pops++;
            chk_eq("pop_while_empty", fifo_empty, 0);
            chk_eq("pop_while_rst_busy", fifo_rst_busy, 0);
            if (!fifo_empty) pop_pending = 1;
        end
        if (m_tvalid && m_tready) model_accept(m_tdata, m_tlast);
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_pkts(input int unsigned target, input int unsigned budget);
        int unsigned n = 0;
        while (pkts_m < target && n < budget) begin
            cycle();
            n++;
        end
        chk_eq($sformatf("pkts_reached_%0d", target), (pkts_m >= target), 1);
    endtask

    task automatic run_until_pops(input int unsigned target, input int unsigned budget);
        int unsigned n = 0;
        while (pops < target && n < budget) begin
            cycle();
            n++;
        end
        chk_eq($sformatf("pops_reached_%0d", target), (pops >= target), 1);
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        fifo_rst_busy = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout = 8'h00;
        m_tready = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk_eq("rst_tvalid", m_tvalid, 0);
        chk_eq("rst_tlast", m_tlast, 0);
        chk_eq("rst_tdata", m_tdata, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_pkt_count", pkt_count, 0);
        chk_eq("rst_rd_en", fifo_rd_en, 0);
        rst = 1'b0;

        // Fixed payload 01..04; held off by FIFO reset-busy first.
        for (int unsigned i = 1; i <= PLEN; i++) push(8'(i));
        en = 1'b1;
        fifo_rst_busy = 1'b1;
        pops = 0;
        run(5);
        chk_eq("rstbusy_idle", busy, 0);
        chk_eq("rstbusy_pops", pops, 0);
        fifo_rst_busy = 1'b0;
        run_until_pkts(1, 200);
        run(2);
        chk_eq("t1_pkt_count", pkt_count, 1);
        chk_eq("t1_busy", busy, 0);
        chk_eq("t1_pops", pops, PLEN);

        // Random backpressure on a random payload.
        rdy_rand = 1;
        for (int unsigned i = 0; i < PLEN; i++) push(8'($urandom));
        run_until_pkts(2, 400);
        rdy_rand = 0;
        run(2);
        chk_eq("t2_pkt_count", pkt_count, 2);

        // FIFO runs dry after two payload bytes.
        pops = 0;
        push(8'($urandom));
        push(8'($urandom));
        run(40);
        chk_eq("gap_tvalid", m_tvalid, 0);
        chk_eq("gap_pops", pops, 2);
        chk_eq("gap_busy", busy, 1);
        for (int unsigned i = 2; i < PLEN; i++) push(8'($urandom));
        run_until_pkts(3, 200);
        run(2);
        chk_eq("t3_pops", pops, PLEN);
        chk_eq("t3_pkt_count", pkt_count, 3);

        // 300 packets back-to-back, seq wraps past FF.
        rdy_rand = 1;
        pops = 0;
        for (int unsigned i = 0; i < 300 * PLEN; i++) push(8'($urandom));
        run_until_pkts(303, 40000);
        rdy_rand = 0;
        run(3);
        chk_eq("t4_pkt_count", pkt_count, 303);
        chk_eq("t4_pops", pops, 300 * PLEN);
        chk_eq("t4_busy", busy, 0);

        // en dropped once payload popping has begun.
        pops = 0;
        for (int unsigned i = 0; i < 2 * PLEN; i++) push(8'($urandom));
        run_until_pops(1, 100);
        en = 1'b0;
        run_until_pkts(304, 200);
        run(30);
        chk_eq("t5_busy", busy, 0);
        chk_eq("t5_pops", pops, PLEN);
        chk_eq("t5_fifo_left", fq.size(), PLEN);
        chk_eq("t5_pkt_count", pkt_count, 304);

        // Reset mid-payload aborts the packet.
        en = 1'b1;
        pops = 0;
        run_until_pops(2, 100);
        rst = 1'b1;
        #1;
        chk_eq("abort_tvalid", m_tvalid, 0);
        chk_eq("abort_tlast", m_tlast, 0);
        chk_eq("abort_tdata", m_tdata, 0);
        chk_eq("abort_busy", busy, 0);
        chk_eq("abort_pkt_count", pkt_count, 0);
        chk_eq("abort_rd_en", fifo_rd_en, 0);
        fq.delete();
        src_q.delete();
        pop_pending = 0;
        stall_prev = 0;
        pos = 0;
        sum_m = 8'h00;
        seq_m = 8'h00;
        pkts_m = 0;
        fifo_empty = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int unsigned i = 0; i < PLEN; i++) push(8'($urandom));
        run_until_pkts(1, 200);
        run(2);
        chk_eq("t6_pkt_count", pkt_count, 1);
        chk_eq("t6_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
